mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Initiator side of the data-memory bus: sits between the CPU's MEM pipeline stage and the word-addressed data memory. Accepts one load/store request at a time and converts byte/halfword/word accesses into word address plus byte enables. Replicates store data onto the lanes and drives chip-select/read-write until the memory signals `DataReady`. Extracts and sign/zero-extends load data and returns a single-cycle response, with error on misalignment or bus timeout.

## Interface
- `TIMEOUT`, 15: maximum WAIT cycles before a timeout error (effective only with `MEM_TIMEOUT_EN`).
- `Clk` in 1: sole clock, rising edge.
- `Reset` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE; a request is accepted on a rising edge with `req_valid & req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `req_signed` in 1: loads sign-extend when 1, zero-extend when 0.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 32: extended load data; 0 for stores and errors.
- `rsp_err` out 1: qualified by `rsp_valid`.
- `CS` out 1: memory chip select.
- `RW` out 1: 1 = write.
- `BE` out 4: byte enables.
- `Addr` out 30: word address, `req_addr[31:2]`.
- `DataOut` out 32: write data to memory.
- `DataIn` in 32: read data from memory.
- `DataReady` in 1: memory completion.

## Operation
- States:
  - **IDLE**: `req_ready`=1. On accept, latch the request.
    - Misaligned → RESP with err. Misaligned means: half with addr[0]=1; word with addr[1:0]≠0; size 11.
    - Otherwise → ISSUE.
  - **ISSUE**: drive the bus for one cycle → WAIT.
  - **WAIT**: hold the bus.
    - `DataReady`=1 → capture `DataIn` → RESP.
    - Timeout → RESP with err.
  - **RESP**: `rsp_valid`=1 for one cycle → IDLE.
- Bus outputs are registered.
  - `CS`=1 in ISSUE and WAIT only; `RW`/`BE`/`Addr`/`DataOut` stay constant through ISSUE and WAIT.
  - In IDLE and RESP: `CS`=0 and `BE`=0. `Addr`, `RW`, `DataOut` hold their last values.
- BE generation:
  - byte: 0001 << addr[1:0].
  - half: addr[1] ? 1100 : 0011.
  - word: 1111.
- Store data: byte → {4{wdata[7:0]}}, half → {2{wdata[15:0]}}, word → wdata.
- Load extraction from the captured word:
  - byte lane = addr[1:0]; half lane = addr[1].
  - Extend to 32 bits per `req_signed`; word loads pass through.
- Misaligned requests never assert `CS`.
- Request inputs are sampled only at accept; later changes are ignored.
- `DataReady` is ignored outside WAIT.

## Timing
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0, `CS`=0, `RW`=0, `BE`=0, `Addr`=0, `DataOut`=0.
- Nominal latency with `DataReady` high, accept at edge E:
  - ISSUE occupies E..E+1.
  - Data is captured at E+2.
  - `rsp_valid` is high during cycle E+2..E+3.
  - Throughput is one access per 4 cycles.
- Misaligned: `rsp_valid`+`rsp_err` in the cycle after accept (latency 1).
- WAIT counter:
  - Cleared on entry to WAIT; increments each WAIT cycle without `DataReady`.
  - When it reaches `TIMEOUT` → RESP with err, `rsp_rdata`=0.
  - `DataReady` in the same cycle as the counter reaching `TIMEOUT` wins, so the access completes normally.
- Reset mid-operation:
  - Immediately drops `CS`/`BE` (asynchronous) and returns to IDLE.
  - No response is issued for the aborted request.
- A new request is not accepted in RESP; `req_ready` rises in the cycle after RESP.

## Configuration
- `MEM_TIMEOUT_EN` defined: WAIT counter and timeout error are compiled in, per `TIMEOUT`.
- Not defined: no counter. WAIT holds indefinitely until `DataReady`; `rsp_err` is asserted only for misalignment.

## Test plan
- Store word `0xDEADBEEF` to `0x08`, then signed load byte at `0x0B` → `BE`=1000 on the read, `rsp_rdata`=`0xFFFFFFDE`; unsigned → `0x000000DE`.
- Store half `0x1234` to `0x06` → `Addr`=1, `BE`=1100, `DataOut`=`0x12341234`, `RW`=1. A load word from `0x04` then returns `0x1234xxxx` in the upper half.
- Load half from `0x03` → `rsp_valid`+`rsp_err` one cycle after accept, `CS` never high, `rsp_rdata`=0.
- Hold `DataReady`=0 with `MEM_TIMEOUT_EN`, `TIMEOUT`=15 → `rsp_err` pulse after exactly 15 WAIT cycles, `CS` high throughout, then `CS`=0 and `req_ready`=1.
- Assert `Reset` during WAIT → `CS`=0 immediately, no `rsp_valid`, `req_ready`=1. The next load of `0x00` completes in 3 cycles.
- Back-to-back `req_valid` held high → accepts spaced exactly 4 cycles apart; bus fields never change while `CS`=1.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: CPU-side request/response handshake plus the
// word-addressed data-memory bus. The controller uses the slave modport;
// the CPU stage / memory model side uses the master modport.
interface mem_access_ctrl_if;
   // CPU request / response
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   // data-memory bus
   logic        CS;
   logic        RW;
   logic [3:0]  BE;
   logic [29:0] Addr;
   logic [31:0] DataOut;
   logic [31:0] DataIn;
   logic        DataReady;

   modport slave (
      input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
      input  DataIn, DataReady,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
      output CS, RW, BE, Addr, DataOut
   );

   modport master (
      output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
      output DataIn, DataReady,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
      input  CS, RW, BE, Addr, DataOut
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding load/store initiator for the data
// memory. Converts byte/half/word requests into word address + byte
// enables, replicates store data across lanes, extracts and extends load
// data, and flags misaligned requests.
// Optional feature macro: MEM_TIMEOUT_EN -- when defined, a WAIT-state
// counter aborts an access with an error after TIMEOUT cycles without
// DataReady; otherwise WAIT holds until DataReady.
module mem_access_ctrl #(
   parameter int TIMEOUT = 15
) (
   input  logic             Clk,
   input  logic             Reset,
   mem_access_ctrl_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t      state_q;
   logic        req_ready_q;
   logic        rsp_valid_q;
   logic        rsp_err_q;
   logic [31:0] rsp_rdata_q;
   logic        cs_q;
   logic        rw_q;
   logic [3:0]  be_q;
   logic [29:0] addr_q;
   logic [31:0] dout_q;
   // Request fields needed later for load extraction
   logic [1:0]  lane_q;
   logic [1:0]  size_q;
   logic        signed_q;

   logic        misaligned_d;
   logic [3:0]  be_d;
   logic [31:0] wdata_d;
   logic [31:0] rdata_d;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] wait_cnt_q;
`else
   // Without the counter the timeout value has no effect.
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT == 0);
`endif

   // Decode the live request: alignment, byte enables, replicated store data
   always_comb begin
      misaligned_d = 1'b0;
      be_d         = 4'b0000;
      wdata_d      = bus.req_wdata;
      case (bus.req_size)
         2'b00: begin
            be_d    = 4'b0001 << bus.req_addr[1:0];
            wdata_d = {4{bus.req_wdata[7:0]}};
         end
         2'b01: begin
            misaligned_d = bus.req_addr[0];
            be_d         = bus.req_addr[1] ? 4'b1100 : 4'b0011;
            wdata_d      = {2{bus.req_wdata[15:0]}};
         end
         2'b10: begin
            misaligned_d = |bus.req_addr[1:0];
            be_d         = 4'b1111;
         end
         default: misaligned_d = 1'b1;
      endcase
   end

   // Pick the addressed lane out of the memory word and extend it
   always_comb begin
      byte_sel = bus.DataIn[7:0];
      case (lane_q)
         2'd1:    byte_sel = bus.DataIn[15:8];
         2'd2:    byte_sel = bus.DataIn[23:16];
         2'd3:    byte_sel = bus.DataIn[31:24];
         default: byte_sel = bus.DataIn[7:0];
      endcase
      half_sel = lane_q[1] ? bus.DataIn[31:16] : bus.DataIn[15:0];
      case (size_q)
         2'b00:   rdata_d = {{24{signed_q & byte_sel[7]}}, byte_sel};
         2'b01:   rdata_d = {{16{signed_q & half_sel[15]}}, half_sel};
         default: rdata_d = bus.DataIn;
      endcase
      // Stores return zero data
      if (rw_q) begin
         rdata_d = 32'h0;
      end
   end

   // Access sequencer with registered handshake and bus outputs
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q     <= S_IDLE;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= 32'h0;
         cs_q        <= 1'b0;
         rw_q        <= 1'b0;
         be_q        <= 4'b0000;
         addr_q      <= 30'h0;
         dout_q      <= 32'h0;
         lane_q      <= 2'b00;
         size_q      <= 2'b00;
         signed_q    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         wait_cnt_q  <= '0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.req_valid) begin
                  req_ready_q <= 1'b0;
                  lane_q      <= bus.req_addr[1:0];
                  size_q      <= bus.req_size;
                  signed_q    <= bus.req_signed;
                  if (misaligned_d) begin
                     // Error straight away; the bus is never touched
                     state_q     <= S_RESP;
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b1;
                     rsp_rdata_q <= 32'h0;
                  end else begin
                     state_q <= S_ISSUE;
                     cs_q    <= 1'b1;
                     rw_q    <= bus.req_we;
                     be_q    <= be_d;
                     addr_q  <= bus.req_addr[31:2];
                     dout_q  <= wdata_d;
                  end
               end
            end
            S_ISSUE: begin
               state_q <= S_WAIT;
`ifdef MEM_TIMEOUT_EN
               wait_cnt_q <= '0;
`endif
            end
            S_WAIT: begin
               // DataReady takes priority over an expiring counter
               if (bus.DataReady) begin
                  state_q     <= S_RESP;
                  cs_q        <= 1'b0;
                  be_q        <= 4'b0000;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b0;
                  rsp_rdata_q <= rdata_d;
               end
`ifdef MEM_TIMEOUT_EN
               else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                  state_q     <= S_RESP;
                  cs_q        <= 1'b0;
                  be_q        <= 4'b0000;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  rsp_rdata_q <= 32'h0;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 1'b1;
               end
`endif
            end
            default: begin
               state_q     <= S_IDLE;
               rsp_valid_q <= 1'b0;
               rsp_err_q   <= 1'b0;
               req_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.CS        = cs_q;
   assign bus.RW        = rw_q;
   assign bus.BE        = be_q;
   assign bus.Addr      = addr_q;
   assign bus.DataOut   = dout_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: randomized and directed bench for mem_access_ctrl.
// Loads are checked against a byte-array reference memory; bus fields
// are checked against byte-lane arithmetic. Build with MEM_TIMEOUT_EN
// defined to exercise the timeout path.
module tb_mem_access_ctrl;
   localparam int TB_TIMEOUT = 15;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   mem_access_ctrl_if bus ();

   mem_access_ctrl #(.TIMEOUT(TB_TIMEOUT)) dut (
      .Clk   (clk),
      .Reset (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Memory device: 16 words, aliased by Addr[3:0]
   logic [31:0] bus_mem [16];
   // Reference view of the same storage, byte addressed
   logic [7:0]  ref_mem [64];

   assign bus.DataIn = bus_mem[bus.Addr[3:0]];

   always @(posedge clk) begin
      if (bus.CS && bus.RW && bus.DataReady) begin
         for (int j = 0; j < 4; j++) begin
            if (bus.BE[j]) bus_mem[bus.Addr[3:0]][8*j +: 8] <= bus.DataOut[8*j +: 8];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int nbytes(input logic [1:0] size);
      return 1 << size;
   endfunction

   function automatic logic is_mis(input logic [1:0] size, input logic [31:0] addr);
      if (size == 2'b11) return 1'b1;
      return (addr % nbytes(size)) != 0;
   endfunction

   function automatic logic [31:0] ref_load(input logic [1:0] size, input logic sgn, input logic [31:0] addr);
      logic [31:0] v;
      int n;
      n = nbytes(size);
      v = 32'h0;
      for (int i = 0; i < n; i++) v = v | (32'(ref_mem[int'(addr[5:0]) + i]) << (8 * i));
      if (n < 4 && sgn && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      return v;
   endfunction

   function automatic logic [3:0] ref_be(input logic [1:0] size, input logic [31:0] addr);
      logic [3:0] be;
      be = 4'b0000;
      for (int i = 0; i < nbytes(size); i++) be[int'(addr[1:0]) + i] = 1'b1;
      return be;
   endfunction

   function automatic logic [31:0] ref_dout(input logic [1:0] size, input logic [31:0] wdata);
      logic [31:0] d;
      d = 32'h0;
      for (int j = 0; j < 4; j++) d[8*j +: 8] = wdata[8*(j % nbytes(size)) +: 8];
      return d;
   endfunction

   task automatic ref_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
      for (int i = 0; i < nbytes(size); i++) ref_mem[int'(addr[5:0]) + i] = wdata[8*i +: 8];
   endtask

   // One complete access; hold = negedges after accept with DataReady forced low,
   // mode 0 = DataReady high afterwards, mode 1 = random (never more than 6 lows in a row)
   task automatic do_txn(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int mode, input int hold,
                         output logic [31:0] rdata, output int lat);
      logic        mis;
      logic        exp_to;
      logic [31:0] exp_rdata;
      int          n;
      int          zeros;
      rdata = 32'h0;
      for (int i = 0; i < 50 && !bus.req_ready; i++) @(negedge clk);
      chk("idle_ready", bus.req_ready, 1);
      mis    = is_mis(size, addr);
      exp_to = 1'b0;
`ifdef MEM_TIMEOUT_EN
      exp_to = !mis && (hold >= TB_TIMEOUT + 1);
`endif
      exp_rdata = (mis || we || exp_to) ? 32'h0 : ref_load(size, sgn, addr);
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_size   = size;
      bus.req_signed = sgn;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      bus.DataReady  = 1'($urandom % 2);
      @(negedge clk);
      // Accepted; scramble the request inputs, which must now be ignored
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'($urandom);
      bus.req_size   = 2'($urandom);
      bus.req_signed = 1'($urandom);
      bus.req_addr   = $urandom;
      bus.req_wdata  = $urandom;
      n = 1;
      zeros = 0;
      if (mis) begin
         chk("mis_valid", bus.rsp_valid, 1);
         chk("mis_err", bus.rsp_err, 1);
         chk("mis_rdata", bus.rsp_rdata, 32'h0);
         chk("mis_cs", bus.CS, 0);
         rdata = bus.rsp_rdata;
      end else begin
         while (!bus.rsp_valid && n < 200) begin
            chk("bus_cs", bus.CS, 1);
            chk("bus_rw", bus.RW, we);
            chk("bus_be", bus.BE, ref_be(size, addr));
            chk("bus_addr", bus.Addr, addr[31:2]);
            if (we) chk("bus_dout", bus.DataOut, ref_dout(size, wdata));
            if (n <= hold) bus.DataReady = 1'b0;
            else if (mode == 0 || zeros >= 6) bus.DataReady = 1'b1;
            else bus.DataReady = 1'($urandom % 2);
            zeros = bus.DataReady ? 0 : zeros + 1;
            @(negedge clk);
            n++;
         end
         chk("rsp_seen", bus.rsp_valid, 1);
`ifdef MEM_TIMEOUT_EN
         if (exp_to) chk("timeout_cs_cycles", n - 1, TB_TIMEOUT + 1);
`endif
         chk("rsp_err", bus.rsp_err, exp_to);
         chk("rsp_rdata", bus.rsp_rdata, exp_rdata);
         chk("rsp_cs", bus.CS, 0);
         rdata = bus.rsp_rdata;
         if (we && !exp_to) ref_store(size, addr, wdata);
      end
      lat = n;
      $display("txn we=%0d size=%0d sgn=%0d addr=%h wdata=%h rdata=%h lat=%0d", we, size, sgn, addr, wdata, rdata, lat);
      @(negedge clk);
      chk("post_valid", bus.rsp_valid, 0);
      chk("post_cs", bus.CS, 0);
      chk("post_be", bus.BE, 4'b0000);
      chk("post_ready", bus.req_ready, 1);
   endtask

   logic [31:0] rd;
   int          lat;
   int          acc;
   int          rsps;
   int          acc_cyc [4];
   logic        drop;
   logic [31:0] exp_b2b;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_size   = 2'b00;
      bus.req_signed = 1'b0;
      bus.req_addr   = 32'h0;
      bus.req_wdata  = 32'h0;
      bus.DataReady  = 1'b0;
      for (int i = 0; i < 16; i++) begin
         logic [31:0] w;
         w = $urandom;
         bus_mem[i] <= w;
         for (int j = 0; j < 4; j++) ref_mem[4*i + j] = w[8*j +: 8];
      end
      repeat (3) @(negedge clk);
      // Reset values
      chk("rst_ready", bus.req_ready, 1);
      chk("rst_valid", bus.rsp_valid, 0);
      chk("rst_err", bus.rsp_err, 0);
      chk("rst_rdata", bus.rsp_rdata, 32'h0);
      chk("rst_cs", bus.CS, 0);
      chk("rst_rw", bus.RW, 0);
      chk("rst_be", bus.BE, 4'b0000);
      chk("rst_addr", bus.Addr, 30'h0);
      chk("rst_dout", bus.DataOut, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      // Word store, then signed and unsigned byte loads from the top lane
      do_txn(1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'hDEAD_BEEF, 0, 0, rd, lat);
      chk("store_lat", lat, 3);
      do_txn(1'b0, 2'b00, 1'b1, 32'h0000_000B, 32'h0, 0, 0, rd, lat);
      chk("lb_signed", rd, 32'hFFFF_FFDE);
      do_txn(1'b0, 2'b00, 1'b0, 32'h0000_000B, 32'h0, 1, 0, rd, lat);
      chk("lb_unsigned", rd, 32'h0000_00DE);

      // Half store to the upper half of word 1, then word load
      do_txn(1'b1, 2'b01, 1'b0, 32'h0000_0006, 32'h0000_1234, 0, 0, rd, lat);
      do_txn(1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'h0, 1, 0, rd, lat);
      chk("lw_upper", rd[31:16], 32'h1234);

      // Misaligned half load
      do_txn(1'b0, 2'b01, 1'b0, 32'h0000_0003, 32'h0, 0, 0, rd, lat);
      chk("mis_lat", lat, 1);

      // Long stall with DataReady low
`ifdef MEM_TIMEOUT_EN
      do_txn(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 0, TB_TIMEOUT + 1, rd, lat);
      chk("timeout_lat", lat, TB_TIMEOUT + 2);
`else
      do_txn(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 0, 40, rd, lat);
      chk("long_wait_lat", lat, 42);
`endif

      // Reset while in WAIT aborts silently
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b0;
      bus.req_size   = 2'b10;
      bus.req_signed = 1'b0;
      bus.req_addr   = 32'h0000_0014;
      bus.DataReady  = 1'b0;
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      chk("abort_cs_wait", bus.CS, 1);
      #2 rst = 1'b1;
      #1;
      chk("abort_cs_async", bus.CS, 0);
      chk("abort_be_async", bus.BE, 4'b0000);
      chk("abort_ready", bus.req_ready, 1);
      chk("abort_valid", bus.rsp_valid, 0);
      @(negedge clk);
      rst = 1'b0;
      bus.DataReady = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("abort_no_rsp", bus.rsp_valid, 0);
         chk("abort_idle_cs", bus.CS, 0);
      end
      do_txn(1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0, 0, 0, rd, lat);
      chk("after_reset_lat", lat, 3);

      // Back-to-back loads with req_valid held high
      exp_b2b = ref_load(2'b10, 1'b0, 32'h0000_000C);
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b0;
      bus.req_size   = 2'b10;
      bus.req_signed = 1'b0;
      bus.req_addr   = 32'h0000_000C;
      bus.DataReady  = 1'b1;
      acc = 0;
      rsps = 0;
      drop = 1'b0;
      for (int i = 0; i < 4; i++) acc_cyc[i] = 0;
      for (int c = 0; c < 60 && rsps < 4; c++) begin
         if (drop) bus.req_valid = 1'b0;
         if (bus.req_valid && bus.req_ready && acc < 4) begin
            acc_cyc[acc] = c;
            acc++;
            if (acc == 4) drop = 1'b1;
         end
         if (bus.CS) begin
            chk("b2b_be", bus.BE, 4'b1111);
            chk("b2b_addr", bus.Addr, 30'h3);
            chk("b2b_rw", bus.RW, 0);
         end
         if (bus.rsp_valid) begin
            rsps++;
            chk("b2b_rdata", bus.rsp_rdata, exp_b2b);
         end
         @(negedge clk);
      end
      bus.req_valid = 1'b0;
      chk("b2b_accepts", acc, 4);
      chk("b2b_rsps", rsps, 4);
      for (int i = 0; i < 3; i++) chk("b2b_spacing", acc_cyc[i+1] - acc_cyc[i], 4);
      $display("txn b2b accepts=%0d rsps=%0d", acc, rsps);
      repeat (2) @(negedge clk);

      // Randomized accesses against the reference memory
      for (int t = 0; t < 40; t++) begin
         logic        we;
         logic [1:0]  size;
         logic        sgn;
         logic [31:0] addr;
         we   = 1'($urandom % 2);
         size = ($urandom % 8 == 0) ? 2'b11 : 2'($urandom % 3);
         sgn  = 1'($urandom % 2);
         addr = $urandom;
         if ($urandom % 5 != 0) begin
            if (size == 2'b01) addr[0] = 1'b0;
            if (size == 2'b10) addr[1:0] = 2'b00;
         end
         do_txn(we, size, sgn, addr, $urandom, int'($urandom % 2), int'($urandom % 4), rd, lat);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
